// File: rtl/multi_ro_trng_pkg.sv
// Shared types, width helpers and parameter legality check for multi_ro_trng.
package multi_ro_trng_pkg;

  // Half-pair state of the von Neumann debiaser.
  typedef enum logic {
    VN_EMPTY      = 1'b0,
    VN_HAVE_FIRST = 1'b1
  } vn_state_e;

  // Shift counter must be able to hold WORD_WIDTH itself (the "full" state).
  function automatic int cnt_width(input int word_width);
    return $clog2(word_width + 1);
  endfunction

  // Run counter saturates at REP_LIMIT, so it must hold that value.
  function automatic int run_width(input int rep_limit);
    return $clog2(rep_limit + 1);
  endfunction

  // Legal parameter set: odd rings of at least 3 stages, at least one ring,
  // words of at least 2 bits and a repetition limit of at least 2.
  function automatic bit params_ok(input int num_ro, input int ro_length,
                                   input int word_width, input int rep_limit);
    return (num_ro >= 1) && (ro_length >= 3) && ((ro_length % 2) == 1) &&
           (word_width >= 2) && (rep_limit >= 2);
  endfunction

endpackage

// File: rtl/ring_oscillator.sv
// Free-running ring oscillator: odd chain of inverters closed through a NAND
// so that en_i=0 parks the ring in a static state.
module ring_oscillator #(
  parameter int LENGTH = 5
) (
  input  logic en_i,
  output logic ro_o
);

  (* dont_touch = "true" *) logic [LENGTH-1:0] stage;

  assign stage[0] = ~(en_i & stage[LENGTH-1]);

  for (genvar i = 1; i < LENGTH; i++) begin : g_inv
    assign stage[i] = ~stage[i-1];
  end

  assign ro_o = stage[LENGTH-1];

endmodule

// File: rtl/trng_vn_debias.sv
// Von Neumann debiaser: consumes raw bits in pairs, forwards the first bit of
// an unequal pair. With vn_en_i=0 every valid bit passes straight through.
module trng_vn_debias
  import multi_ro_trng_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic vn_en_i,
  input  logic bit_i,
  input  logic vld_i,
  output logic bit_o,
  output logic vld_o
);

  vn_state_e state_q, state_d, state_eff;
  logic      first_q, first_d;
  logic      vn_en_q;

  // State register; vn_en_q remembers the mode so a mode change can drop a half pair.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= VN_EMPTY;
      first_q <= 1'b0;
      vn_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      vn_en_q <= vn_en_i;
    end
  end

  // Pair logic; a mode change in this cycle makes the stored half pair void.
  always_comb begin
    state_eff = (vn_en_i != vn_en_q) ? VN_EMPTY : state_q;
    state_d   = state_eff;
    first_d   = first_q;
    bit_o     = vn_en_i ? first_q : bit_i;
    vld_o     = 1'b0;
    if (vld_i) begin
      if (!vn_en_i) begin
        vld_o = 1'b1;
      end else begin
        case (state_eff)
          VN_EMPTY: begin
            first_d = bit_i;
            state_d = VN_HAVE_FIRST;
          end
          VN_HAVE_FIRST: begin
            state_d = VN_EMPTY;
            vld_o   = (first_q != bit_i);
          end
          default: state_d = VN_EMPTY;
        endcase
      end
    end
  end

endmodule

// File: rtl/multi_ro_trng.sv
// Multi-ring-oscillator TRNG: XOR of NUM_RO rings sampled by iClk, optional
// von Neumann debias, repetition-count health test, word packer with a
// valid/ready output and sticky alarm/overflow flags.
module multi_ro_trng
  import multi_ro_trng_pkg::*;
#(
  parameter int NUM_RO     = 4,
  parameter int RO_LENGTH  = 5,
  parameter int WORD_WIDTH = 32,
  parameter int REP_LIMIT  = 16
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iEntropyEn,
  input  logic                  iEn,
  input  logic                  iVnEn,
  input  logic                  iBypass,
  input  logic                  iBypassBit,
  input  logic                  iReady,
  input  logic                  iClrAlarm,
  output logic [WORD_WIDTH-1:0] oData,
  output logic                  oValid,
  output logic                  oAlarm,
  output logic                  oOverflow
);

  localparam int CNT_W = cnt_width(WORD_WIDTH);
  localparam int RUN_W = run_width(REP_LIMIT);

  if (!params_ok(NUM_RO, RO_LENGTH, WORD_WIDTH, REP_LIMIT)) begin : g_param_err
    $error("multi_ro_trng: illegal parameter set");
  end

  (* dont_touch = "true" *) logic [NUM_RO-1:0] ro_out;

  for (genvar g = 0; g < NUM_RO; g++) begin : g_ro
    (* dont_touch = "true" *)
    ring_oscillator #(.LENGTH(RO_LENGTH)) u_ro (
      .en_i (iEntropyEn),
      .ro_o (ro_out[g])
    );
  end

  logic src_bit;
  assign src_bit = iBypass ? iBypassBit : ^ro_out;

  // Stages S and R also act as a two-flop synchronizer for the async ring output.
  logic s_bit_q, s_vld_q, raw_bit_q, raw_vld_q;

  // Sample stage S then raw stage R; a low iEn inserts a bubble and holds s_bit.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      s_bit_q   <= 1'b0;
      s_vld_q   <= 1'b0;
      raw_bit_q <= 1'b0;
      raw_vld_q <= 1'b0;
    end else begin
      s_vld_q   <= iEn;
      if (iEn) s_bit_q <= src_bit;
      raw_bit_q <= s_bit_q;
      raw_vld_q <= s_vld_q;
    end
  end

  logic             seen_q, last_q, hit_q, alarm_q;
  logic [RUN_W-1:0] run_q, run_d;

  // Next run length: restart on a change or the first bit, else count and saturate.
  always_comb begin
    run_d = run_q;
    if (!seen_q || (raw_bit_q != last_q)) run_d = RUN_W'(1);
    else if (run_q != RUN_W'(REP_LIMIT))  run_d = run_q + RUN_W'(1);
  end

  // Repetition test; the alarm sets one edge after the limit is reached, set beats clear.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      seen_q  <= 1'b0;
      last_q  <= 1'b0;
      run_q   <= '0;
      hit_q   <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      if (raw_vld_q) begin
        seen_q <= 1'b1;
        last_q <= raw_bit_q;
        run_q  <= run_d;
        hit_q  <= (run_d == RUN_W'(REP_LIMIT));
      end
      if (hit_q)          alarm_q <= 1'b1;
      else if (iClrAlarm) alarm_q <= 1'b0;
    end
  end

  logic pk_bit, pk_vld;

  trng_vn_debias u_vn (
    .clk_i   (iClk),
    .rst_i   (iRst),
    .vn_en_i (iVnEn),
    .bit_i   (raw_bit_q),
    .vld_i   (raw_vld_q),
    .bit_o   (pk_bit),
    .vld_o   (pk_vld)
  );

  logic [WORD_WIDTH-1:0] shift_q, shift_d, data_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  valid_q, ovf_q, xfer, full;

  assign xfer    = valid_q & iReady;
  assign full    = (cnt_q == CNT_W'(WORD_WIDTH));
  assign shift_d = {shift_q[WORD_WIDTH-2:0], pk_bit};

  // Packer and output register; a full shifter refills oData on transfer, else bits drop.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      shift_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (full) begin
        if (xfer) begin
          data_q  <= shift_q;
          shift_q <= shift_d;
          cnt_q   <= pk_vld ? CNT_W'(1) : CNT_W'(0);
        end
      end else begin
        if (xfer) valid_q <= 1'b0;
        if (pk_vld) begin
          if ((cnt_q == CNT_W'(WORD_WIDTH - 1)) && (!valid_q || xfer)) begin
            data_q  <= shift_d;
            valid_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
      end
      if (full && !xfer && pk_vld) ovf_q <= 1'b1;
      else if (iClrAlarm)          ovf_q <= 1'b0;
    end
  end

  assign oData     = data_q;
  assign oValid    = valid_q;
  assign oAlarm    = alarm_q;
  assign oOverflow = ovf_q;

endmodule

// File: tb/tb_multi_ro_trng.sv
// Bench for multi_ro_trng: behavioural model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_multi_ro_trng;

  localparam int W   = 8;
  localparam int REP = 16;

  logic iClk = 1'b0, iRst = 1'b0, iEntropyEn = 1'b0, iEn = 1'b0, iVnEn = 1'b0;
  logic iBypass = 1'b1, iBypassBit = 1'b0, iReady = 1'b0, iClrAlarm = 1'b0;
  logic [W-1:0] oData;
  logic oValid, oAlarm, oOverflow;

  int n_chk = 0, n_fail = 0;
  bit chk_on = 1'b0;

  always #5 iClk = ~iClk;

  // Rings stay disabled: a zero-delay oscillating loop cannot be simulated.
  multi_ro_trng #(.NUM_RO(4), .RO_LENGTH(5), .WORD_WIDTH(W), .REP_LIMIT(REP)) dut (
    .iClk(iClk), .iRst(iRst), .iEntropyEn(iEntropyEn), .iEn(iEn), .iVnEn(iVnEn),
    .iBypass(iBypass), .iBypassBit(iBypassBit), .iReady(iReady), .iClrAlarm(iClrAlarm),
    .oData(oData), .oValid(oValid), .oAlarm(oAlarm), .oOverflow(oOverflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int       pipe[$];     // samples in flight: -1 = none, else the bit
  int       run_len, last_raw, first_bit;
  bit       vn_prev, have_first, m_hit;
  int       bq[$];       // bits collected for the next word, oldest first
  logic [W-1:0] m_data;
  bit       m_valid, m_alarm, m_ovf;

  function automatic logic [W-1:0] pack_word();
    logic [W-1:0] w = '0;
    foreach (bq[i]) w = {w[W-2:0], 1'(bq[i])};
    return w;
  endfunction

  function automatic void model_reset();
    pipe = '{-1, -1};
    run_len = 0; last_raw = -1; first_bit = 0;
    vn_prev = 1'b0; have_first = 1'b0; m_hit = 1'b0;
    bq.delete();
    m_data = '0; m_valid = 1'b0; m_alarm = 1'b0; m_ovf = 1'b0;
  endfunction

  function automatic void model_step();
    int raw, pbit;
    bit xfer, was_valid, ovf_set;
    raw = pipe.pop_front();
    pipe.push_back(iEn ? int'(iBypassBit) : -1);
    // repetition test
    if (m_hit) m_alarm = 1'b1;
    else if (iClrAlarm) m_alarm = 1'b0;
    m_hit = 1'b0;
    if (raw >= 0) begin
      if (raw == last_raw) run_len++;
      else run_len = 1;
      last_raw = raw;
      m_hit = (run_len >= REP);
    end
    // debias
    if (iVnEn != vn_prev) have_first = 1'b0;
    vn_prev = iVnEn;
    pbit = -1;
    if (raw >= 0) begin
      if (!iVnEn) pbit = raw;
      else if (!have_first) begin first_bit = raw; have_first = 1'b1; end
      else begin
        have_first = 1'b0;
        if (first_bit != raw) pbit = first_bit;
      end
    end
    // packing and handshake
    was_valid = m_valid;
    xfer = m_valid && iReady;
    ovf_set = 1'b0;
    if (bq.size() == W) begin
      if (xfer) begin
        m_data = pack_word();
        bq.delete();
        if (pbit >= 0) bq.push_back(pbit);
      end else if (pbit >= 0) ovf_set = 1'b1;
    end else begin
      if (xfer) m_valid = 1'b0;
      if (pbit >= 0) begin
        bq.push_back(pbit);
        if (bq.size() == W && (!was_valid || xfer)) begin
          m_data = pack_word();
          m_valid = 1'b1;
          bq.delete();
        end
      end
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (iClrAlarm) m_ovf = 1'b0;
  endfunction

  always @(posedge iClk or posedge iRst) begin
    if (iRst) model_reset();
    else model_step();
  end

  // Per-cycle comparison against the model, plus a log of transferred words.
  logic [W-1:0] got_q[$];
  always @(negedge iClk) begin
    if (chk_on) begin
      check("oData", 32'(oData), 32'(m_data));
      check("oValid", 32'(oValid), 32'(m_valid));
      check("oAlarm", 32'(oAlarm), 32'(m_alarm));
      check("oOverflow", 32'(oOverflow), 32'(m_ovf));
    end
    if (!iRst && oValid && iReady) got_q.push_back(oData);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge iClk);
    #2;
  endtask

  task automatic feed(input logic b);
    iEn = 1'b1;
    iBypassBit = b;
    tick();
  endtask

  task automatic idle(input int n);
    iEn = 1'b0;
    repeat (n) tick();
  endtask

  task automatic feed_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) feed(w[i]);
  endtask

  task automatic do_reset();
    iEn = 1'b0;
    iClrAlarm = 1'b0;
    @(negedge iClk);
    #1 iRst = 1'b1;
    tick();
    iRst = 1'b0;
  endtask

  logic [15:0] vn_pairs;
  logic [15:0] gap_seq;

  initial begin
    #1 iRst = 1'b1;
    #1;
    check("reset oData", 32'(oData), 32'h0);
    check("reset oValid", 32'(oValid), 32'h0);
    check("reset oAlarm", 32'(oAlarm), 32'h0);
    check("reset oOverflow", 32'(oOverflow), 32'h0);
    tick();
    iRst = 1'b0;
    chk_on = 1'b1;

    // 1: raw packing, exact latency
    iReady = 1'b1;
    iVnEn = 1'b0;
    feed_word(8'hB2);
    iEn = 1'b0;
    tick();
    tick();
    @(negedge iClk);
    check("t1 oValid", 32'(oValid), 32'h1);
    check("t1 oData", 32'(oData), 32'hB2);
    tick();
    @(negedge iClk);
    check("t1 oValid drop", 32'(oValid), 32'h0);

    // 2: von Neumann pairs 01,10,11,00 x4
    do_reset();
    iVnEn = 1'b1;
    iReady = 1'b1;
    idle(2);
    got_q.delete();
    vn_pairs = 16'b0110_1100_0000_0000;
    for (int g = 0; g < 4; g++)
      for (int i = 15; i >= 8; i--) feed(vn_pairs[i]);
    idle(4);
    check("t2 words", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("t2 word", 32'(got_q[0]), 32'h55);

    // 3: back-pressure, hold, overflow, drain
    do_reset();
    iVnEn = 1'b0;
    iReady = 1'b0;
    idle(2);
    got_q.delete();
    feed_word(8'hA5);
    feed_word(8'h3C);
    feed_word(8'hFF);
    idle(3);
    @(negedge iClk);
    check("t3 held valid", 32'(oValid), 32'h1);
    check("t3 held data", 32'(oData), 32'hA5);
    check("t3 overflow", 32'(oOverflow), 32'h1);
    tick();
    iReady = 1'b1;
    tick();
    @(negedge iClk);
    check("t3 second valid", 32'(oValid), 32'h1);
    check("t3 second data", 32'(oData), 32'h3C);
    tick();
    @(negedge iClk);
    check("t3 drained", 32'(oValid), 32'h0);
    check("t3 transfers", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      check("t3 xfer0", 32'(got_q[0]), 32'hA5);
      check("t3 xfer1", 32'(got_q[1]), 32'h3C);
    end
    tick();
    iClrAlarm = 1'b1;
    tick();
    iClrAlarm = 1'b0;
    @(negedge iClk);
    check("t3 overflow cleared", 32'(oOverflow), 32'h0);

    // 4: repetition alarm
    do_reset();
    iReady = 1'b1;
    for (int i = 0; i < REP; i++) feed(1'b1);
    iEn = 1'b0;
    tick();
    tick();
    @(negedge iClk);
    check("t4 alarm not yet", 32'(oAlarm), 32'h0);
    tick();
    @(negedge iClk);
    check("t4 alarm set", 32'(oAlarm), 32'h1);
    iClrAlarm = 1'b1;
    tick();
    iClrAlarm = 1'b0;
    @(negedge iClk);
    check("t4 alarm cleared", 32'(oAlarm), 32'h0);
    feed(1'b0);
    for (int i = 0; i < REP - 1; i++) feed(1'b1);
    feed(1'b0);
    idle(4);
    @(negedge iClk);
    check("t4 short run", 32'(oAlarm), 32'h0);

    // 5: asynchronous reset mid-word with a word pending
    do_reset();
    iVnEn = 1'b0;
    iReady = 1'b0;
    feed_word(8'hC3);
    feed(1'b1);
    feed(1'b1);
    feed(1'b1);
    idle(3);
    @(negedge iClk);
    check("t5 pending", 32'(oValid), 32'h1);
    #1 iRst = 1'b1;
    #1;
    check("t5 async oValid", 32'(oValid), 32'h0);
    check("t5 async oData", 32'(oData), 32'h0);
    check("t5 async oAlarm", 32'(oAlarm), 32'h0);
    check("t5 async oOverflow", 32'(oOverflow), 32'h0);
    tick();
    iRst = 1'b0;
    got_q.delete();
    iReady = 1'b1;
    feed_word(8'h96);
    idle(4);
    check("t5 words", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("t5 post-reset word", 32'(got_q[0]), 32'h96);

    // 6: iEn gap mid-word and mid-pair with debias on
    do_reset();
    iVnEn = 1'b1;
    iReady = 1'b1;
    idle(2);
    got_q.delete();
    gap_seq = 16'b10_01_10_10_01_01_10_01;
    for (int i = 15; i >= 11; i--) feed(gap_seq[i]);
    idle(5);
    for (int i = 10; i >= 0; i--) feed(gap_seq[i]);
    idle(4);
    check("t6 words", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("t6 gap word", 32'(got_q[0]), 32'hB2);

    // randomized traffic, model checked every cycle
    do_reset();
    for (int seg = 0; seg < 20; seg++) begin
      bit biased;
      biased = (seg % 3 == 2);
      iVnEn = 1'($urandom_range(0, 1));
      for (int c = 0; c < 150; c++) begin
        iEn = ($urandom_range(0, 3) != 0);
        iBypassBit = biased ? 1'($urandom_range(0, 19) != 0) : 1'($urandom_range(0, 1));
        iReady = 1'($urandom_range(0, 1));
        iClrAlarm = ($urandom_range(0, 49) == 0);
        if ($urandom_range(0, 99) == 0) iVnEn = ~iVnEn;
        tick();
      end
    end
    iClrAlarm = 1'b0;
    iReady = 1'b1;
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
